// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one e4m3 ALU between two requesters.
// Defining ALU_ARB_TIMEOUT_EN adds a WAIT timeout (TIMEOUT cycles) that returns an error response.
module alu_arbiter #(
    parameter int MIN_LAT = 1
`ifdef ALU_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic       clock,
    input  logic       reset,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req0_op,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req1_op,

    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_y,
    output logic       rsp0_err,

    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_y,
    output logic       rsp1_err,

    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctrl,
    input  logic [7:0] alu_y,
    input  logic       alu_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] LAT_INIT = 4'(MIN_LAT - 1);

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       owner_q, owner_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] y_q, y_d;
    logic [3:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;
`endif

    logic       gnt0, gnt1, hs, legal, rsp_hs;
    logic [7:0] sel_a, sel_b;
    logic [3:0] sel_op;

    // Ties go to the requester that did not win last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE) begin
            gnt0 = req0_valid && (!req1_valid || last_grant_q);
            gnt1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign hs         = gnt0 | gnt1;
    assign sel_a      = gnt1 ? req1_a  : req0_a;
    assign sel_b      = gnt1 ? req1_b  : req0_b;
    assign sel_op     = gnt1 ? req1_op : req0_op;
    assign legal      = (sel_op == OP_ADD) || (sel_op == OP_MUL);
    assign rsp_hs     = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        y_d          = y_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
`ifdef ALU_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    owner_d      = gnt1;
                    last_grant_d = gnt1;
                    op_d         = sel_op;
                    if (legal) begin
                        // Operands only move for legal ops so an illegal request leaves the ALU untouched.
                        a_d     = sel_a;
                        b_d     = sel_b;
                        cnt_d   = LAT_INIT;
                        state_d = S_ISSUE;
                    end else begin
                        y_d     = 8'h00;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (alu_valid) begin
                    y_d     = alu_y;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef ALU_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    y_d     = 8'h00;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            op_q         <= 4'b0000;
            y_q          <= 8'h00;
            err_q        <= 1'b0;
            cnt_q        <= 4'd0;
`ifdef ALU_ARB_TIMEOUT_EN
            tmo_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            y_q          <= y_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
`ifdef ALU_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? op_q : 4'b0000;

    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) &&  owner_q;
    assign rsp0_y     = rsp0_valid ? y_q : 8'h00;
    assign rsp1_y     = rsp1_valid ? y_q : 8'h00;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub ALU, transaction-level model checked every cycle, directed vectors.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int ML    = 2;
    localparam int TMO   = 8;
    localparam int NEVER = 255;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic [3:0] req0_op = 4'd0, req1_op = 4'd0;
    logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [7:0] rsp0_y, rsp1_y;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [3:0] alu_ctrl;
    logic       alu_valid;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_arbiter #(
        .MIN_LAT(ML)
`ifdef ALU_ARB_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_valid(alu_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stub ALU: result valid once the op has been presented for stub_lat cycles; stale mode
    // keeps valid high with a junk result beforehand, like a leftover from old operands.
    int stub_lat = 0;
    bit stale = 1'b0;
    int act_cnt = 0;
    logic stub_rdy;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case ({op, a, b})
            {4'd1, 8'h38, 8'h38}: return 8'h40;
            {4'd2, 8'h40, 8'h3C}: return 8'h44;
            {4'd1, 8'h40, 8'h40}: return 8'h48;
            {4'd2, 8'h38, 8'h38}: return 8'h38;
            default:              return a ^ b;
        endcase
    endfunction

    always @(posedge clock) act_cnt <= (alu_ctrl != 4'd0) ? act_cnt + 1 : 0;

    always_comb begin
        stub_rdy  = (stub_lat != NEVER) && (act_cnt >= stub_lat);
        alu_valid = stub_rdy || stale;
        alu_y     = stub_rdy ? ref_alu(alu_a, alu_b, alu_ctrl) : 8'h55;
    end

    // Transaction model: one job in flight, response due at a computed sample index.
    int n = 0;
    bit busy = 1'b0, lg = 1'b1, own = 1'b0, legal = 1'b0, seen = 1'b0;
    int due = 0, acc_n = 0, got_lat = 0;
    logic [7:0] ea, eb, ey, got_y;
    logic [3:0] eop;
    logic eerr, got_err;
    bit obs_gnt[$];
    int acc_hist[$];

    always @(negedge clock) begin
        bit e0, e1, rv, ov, rr;
        logic [7:0] yy;
        logic ee;
        n++;
        if (reset) begin
            busy = 1'b0;
            lg   = 1'b1;
        end else if (!busy) begin
            e0 = req0_valid && (!req1_valid || lg);
            e1 = req1_valid && (!req0_valid || !lg);
            chk("req0_ready", req0_ready, e0);
            chk("req1_ready", req1_ready, e1);
            chk("rsp0_valid_idle", rsp0_valid, 0);
            chk("rsp1_valid_idle", rsp1_valid, 0);
            chk("alu_ctrl_idle", alu_ctrl, 0);
            if (req0_valid && req0_ready) obs_gnt.push_back(1'b0);
            if (req1_valid && req1_ready) obs_gnt.push_back(1'b1);
            if (e0 || e1) begin
                own   = e1;
                lg    = e1;
                busy  = 1'b1;
                seen  = 1'b0;
                acc_n = n;
                acc_hist.push_back(n);
                ea    = e1 ? req1_a  : req0_a;
                eb    = e1 ? req1_b  : req0_b;
                eop   = e1 ? req1_op : req0_op;
                legal = (eop == 4'd1) || (eop == 4'd2);
                if (!legal) begin
                    due = n + 1; ey = 8'h00; eerr = 1'b1;
                end else if (stub_lat == NEVER) begin
`ifdef ALU_ARB_TIMEOUT_EN
                    due = n + ML + 1 + TMO;
`else
                    due = 1 << 30;
`endif
                    ey = 8'h00; eerr = 1'b1;
                end else begin
                    due  = n + 2 + ((stub_lat > ML) ? stub_lat : ML);
                    ey   = ref_alu(ea, eb, eop);
                    eerr = 1'b0;
                end
            end
        end else begin
            chk("req0_ready_busy", req0_ready, 0);
            chk("req1_ready_busy", req1_ready, 0);
            rv = own ? rsp1_valid : rsp0_valid;
            ov = own ? rsp0_valid : rsp1_valid;
            rr = own ? rsp1_ready : rsp0_ready;
            chk("rsp_valid", rv, n >= due);
            chk("rsp_other_valid", ov, 0);
            chk("alu_ctrl", alu_ctrl, (legal && n < due) ? eop : 4'd0);
            if (legal && n < due) begin
                chk("alu_a", alu_a, ea);
                chk("alu_b", alu_b, eb);
            end
            if (n >= due) begin
                yy = own ? rsp1_y : rsp0_y;
                ee = own ? rsp1_err : rsp0_err;
                chk("rsp_y", yy, ey);
                chk("rsp_err", ee, eerr);
                if (!seen) begin
                    seen = 1'b1; got_lat = n - acc_n; got_y = yy; got_err = ee;
                end
                if (rr) busy = 1'b0;
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clock);
        #1;
    endtask

    task automatic send(input bit p, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        bit ok = 1'b0;
        if (p) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else   begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            ok = p ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        tick(1);
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
        chk("accept_bound", ok, 1);
    endtask

    task automatic wait_rsp(input bit p);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            ok = p ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
        end
        tick(1);
        chk("rsp_bound", ok, 1);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
        chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
        chk({tag, "_rsp_err"}, {rsp0_err, rsp1_err}, 0);
        chk({tag, "_rsp_y"}, {rsp0_y, rsp1_y}, 0);
        chk({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
        chk({tag, "_alu_ctrl"}, alu_ctrl, 0);
    endtask

    initial begin
        int base;
        tick(3);
        reset = 1'b0;
        reset_vals("reset");

        // Tie: both hold valid for six grants; first tie goes to req0.
        stub_lat = 1;
        base = obs_gnt.size();
        req0_a = 8'h38; req0_b = 8'h38; req0_op = 4'd1;
        req1_a = 8'h40; req1_b = 8'h3C; req1_op = 4'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 400 && obs_gnt.size() < base + 6; i++) @(posedge clock);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("tie_count", obs_gnt.size(), base + 6);
        wait_rsp(1);
        for (int i = 0; i < 6; i++)
            if (base + i < obs_gnt.size()) chk($sformatf("tie_grant%0d", i), obs_gnt[base+i], i % 2);

        // 1.0 + 1.0 with the ALU ready on the first WAIT cycle: minimum latency.
        stub_lat = 0;
        send(0, 8'h38, 8'h38, 4'd1);
        wait_rsp(0);
        chk("add_y", got_y, 8'h40);
        chk("add_err", got_err, 0);
        chk("add_lat", got_lat, 4);

        // 2.0 * 1.5 with slow ALU and delayed rsp1_ready.
        stub_lat = 5;
        rsp1_ready = 1'b0;
        send(1, 8'h40, 8'h3C, 4'd2);
        tick(10);
        rsp1_ready = 1'b1;
        wait_rsp(1);
        chk("mul_y", got_y, 8'h44);
        chk("mul_lat", got_lat, 7);

        // Stale valid during ISSUE must be masked.
        stale = 1'b1; stub_lat = 2;
        send(0, 8'h40, 8'h40, 4'd1);
        wait_rsp(0);
        stale = 1'b0;
        chk("stale_y", got_y, 8'h48);
        chk("stale_lat", got_lat, 4);

        stub_lat = 1;
        send(1, 8'h38, 8'h38, 4'd2);
        wait_rsp(1);
        chk("mul1_y", got_y, 8'h38);

        // Illegal op: immediate error response.
        send(0, 8'h12, 8'h34, 4'd7);
        wait_rsp(0);
        chk("ill_y", got_y, 8'h00);
        chk("ill_err", got_err, 1);
        chk("ill_lat", got_lat, 1);

        // Back-to-back throughput on one port.
        stub_lat = 0;
        base = acc_hist.size();
        req0_a = 8'h38; req0_b = 8'h38; req0_op = 4'd2; req0_valid = 1'b1;
        for (int i = 0; i < 100 && acc_hist.size() < base + 2; i++) @(posedge clock);
        #1;
        req0_valid = 1'b0;
        wait_rsp(0);
        if (acc_hist.size() >= base + 2) chk("b2b_period", acc_hist[base+1] - acc_hist[base], ML + 3);
        else chk("b2b_count", acc_hist.size(), base + 2);

        // ALU that never answers.
        stub_lat = NEVER;
        send(0, 8'h38, 8'h38, 4'd1);
`ifdef ALU_ARB_TIMEOUT_EN
        wait_rsp(0);
        chk("tmo_y", got_y, 8'h00);
        chk("tmo_err", got_err, 1);
        chk("tmo_lat", got_lat, ML + 1 + TMO);
        send(0, 8'h38, 8'h38, 4'd1);
        tick(6);
`else
        tick(100);
        chk("hang_rsp0_valid", rsp0_valid, 0);
        chk("hang_alu_ctrl", alu_ctrl, 4'd1);
`endif

        // Reset during WAIT drops the transaction.
        rsp0_ready = 1'b1;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        reset_vals("midrst");
        tick(20);
        chk("midrst_no_rsp", rsp0_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
